pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Owns the 6-bit program counter register and sequences instruction fetch for the i281 core: drives `current_pc` and `offset` into the `pc_update` block and loads its `next_pc` result when the executing instruction retires. Talks to instruction memory over a request/acknowledge handshake and presents the held instruction to the opcode decoder with a valid/done handshake. Also supports start/halt control and keeps a saturating retired-instruction count for debug.

## Interface
- `PC_W`, 6, program counter and instruction-memory address width
- `INSTR_W`, 16, instruction word width
- `CNT_W`, 16, retired-instruction counter width

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; leave HALT and begin fetching at the current `pc`
- `halt_req`  in  1  pulse; stop after the in-flight instruction retires
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  PC_W  fetch address (= `pc`)
- `imem_ack`  in  1  `imem_data` valid this cycle
- `imem_data`  in  INSTR_W  instruction word from memory
- `instr`  out  INSTR_W  held instruction register, to decoder
- `instr_valid`  out  1  `instr` is valid and executing
- `instr_done`  in  1  execute stage retires `instr`; `next_pc` valid this cycle
- `current_pc`  out  PC_W  to `pc_update`
- `offset`  out  6  `instr[5:0]`, to `pc_update`
- `next_pc`  in  PC_W  from `pc_update` (branch decision `c2` goes to `pc_update` directly)
- `running`  out  1  high whenever state is not HALT
- `retired`  out  CNT_W  count of retired instructions, saturating

## Operation
- States: HALT, FETCH, EXEC. One-hot or binary encoding is an implementer choice.
- HALT: `imem_req`=0, `instr_valid`=0. `start`=1 moves to FETCH and clears `halt_pending`.
- FETCH: `imem_req`=1, `imem_addr`=`pc` held stable until ack. `imem_ack`=1 loads `instr`<=`imem_data` and moves to EXEC.
- EXEC: `instr_valid`=1. `instr_done`=1 loads `pc`<=`next_pc` and increments `retired`. The next state is HALT if `halt_pending` or `halt_req` is set, otherwise FETCH.
- `halt_req` in FETCH or EXEC sets `halt_pending`. The in-flight fetch completes and its instruction executes before the halt. `halt_pending` clears on entering HALT. `halt_req` in HALT is ignored.
- `start` outside HALT is ignored. If `start` and `halt_req` are both high in HALT, the block starts and sets `halt_pending`, so exactly one instruction executes.
- `imem_ack` outside FETCH and `instr_done` outside EXEC are ignored, with no state change.
- PC arithmetic: no arithmetic is done here. `pc` loads `next_pc` verbatim, so wrap-around modulo 2^PC_W (63 -> 0, and negative offsets) is `pc_update`'s result. `pc` is otherwise preserved across HALT, so a restart resumes at the stored `pc`.
- `retired` saturates at 2^CNT_W-1 and does not wrap.
- `current_pc` = `imem_addr` = `pc`. `offset` = `instr[5:0]`.

## Timing
- Reset (async assert, sync-safe release): `pc`=0, `instr`=0, `instr_valid`=0, `imem_req`=0, `running`=0, `retired`=0, `halt_pending`=0, state HALT.
- Reset asserted mid-fetch or mid-exec abandons the instruction immediately. No retire count is taken and `pc` returns to 0.
- `start` high at edge t: `imem_req`=1 and `running`=1 from t+1.
- Zero-wait memory: with `imem_ack` in the first FETCH cycle, `instr_valid`=1 the next cycle.
- `instr_done` in the same cycle `instr_valid` rises: `pc` updates and FETCH resumes next cycle. The minimum is 2 cycles per instruction.
- `instr`, `instr_valid`, `offset` stay stable for the entire EXEC state.
- All outputs are registered or decoded from registered state. No input-to-output combinational path exists.

## Test plan
- Reset, then `start`. Memory acks the first request cycle with 0x1234 at addr 0. Expect: `imem_req` in cycle 1, `instr`=0x1234 with `instr_valid` in cycle 2, `offset`=0x34.
- Sequential run: drive `next_pc`=`pc`+1, memory with 3 wait cycles, `instr_done` one cycle after `instr_valid`, 5 instructions. Expect: `imem_addr` goes 0,1,2,3,4 and `retired`=5.
- Branch wrap: `pc`=62 with `next_pc`=3 on `instr_done`. Expect: next `imem_addr`=3. Then `pc`=63 with `next_pc`=0. Expect: fetch at 0.
- `halt_req` during FETCH wait. Expect: the instruction still executes, `pc` loads `next_pc`, then HALT with `imem_req`=0. A second `start` fetches from the updated `pc`.
- `imem_ack` in EXEC and `instr_done` in FETCH and HALT. Expect: no change to `instr`, `pc`, or `retired`.
- `rst_n` low mid-EXEC at `pc`=17 and `retired`=9. Expect: outputs reset immediately, `pc`=0, `retired`=0. Also preload `retired`=0xFFFE, retire 3 instructions, and expect `retired`=0xFFFF.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer for the i281 core.
// HALT -> FETCH (imem req/ack) -> EXEC (valid/done) loop with start/halt control.
module pc_fetch_sequencer #(
    parameter int unsigned PC_W    = 6,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_halt_req,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    input  logic               i_instr_done,
    output logic [PC_W-1:0]    o_current_pc,
    output logic [5:0]         o_offset,
    input  logic [PC_W-1:0]    i_next_pc,
    output logic               o_running,
    output logic [CNT_W-1:0]   o_retired
);

    typedef enum logic [1:0] {
        StHalt  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_halt_pending;
    logic [CNT_W-1:0]     r_retired;

    state_t               w_state_next;
    logic [PC_W-1:0]      w_pc_next;
    logic [INSTR_W-1:0]   w_instr_next;
    logic                 w_halt_pending_next;
    logic [CNT_W-1:0]     w_retired_next;
    logic [CNT_W-1:0]     w_retired_inc;

    // Saturating increment: the debug counter sticks at all-ones instead of wrapping.
    assign w_retired_inc = (r_retired == CntMax) ? r_retired : r_retired + CntOne;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StHalt;
            r_pc           <= '0;
            r_instr        <= '0;
            r_halt_pending <= 1'b0;
            r_retired      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_instr        <= w_instr_next;
            r_halt_pending <= w_halt_pending_next;
            r_retired      <= w_retired_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_instr_next        = r_instr;
        w_halt_pending_next = r_halt_pending;
        w_retired_next      = r_retired;
        unique case (r_state)
            StHalt: begin
                // A halt_req arriving with start arms the halt so exactly one instruction runs.
                if (i_start) begin
                    w_state_next        = StFetch;
                    w_halt_pending_next = i_halt_req;
                end
            end
            StFetch: begin
                if (i_halt_req) begin
                    w_halt_pending_next = 1'b1;
                end
                if (i_imem_ack) begin
                    w_instr_next = i_imem_data;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (i_instr_done) begin
                    w_pc_next      = i_next_pc;
                    w_retired_next = w_retired_inc;
                    if (r_halt_pending || i_halt_req) begin
                        w_state_next        = StHalt;
                        w_halt_pending_next = 1'b0;
                    end else begin
                        w_state_next = StFetch;
                    end
                end else if (i_halt_req) begin
                    w_halt_pending_next = 1'b1;
                end
            end
            default: begin
                w_state_next        = StHalt;
                w_halt_pending_next = 1'b0;
            end
        endcase
    end

    assign o_imem_req    = (r_state == StFetch);
    assign o_instr_valid = (r_state == StExec);
    assign o_running     = (r_state != StHalt);
    assign o_imem_addr   = r_pc;
    assign o_current_pc  = r_pc;
    assign o_instr       = r_instr;
    assign o_offset      = r_instr[5:0];
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized runs
// scored against a transaction-level model; a narrow-counter twin exercises saturation.
module tb_pc_fetch_sequencer;

    localparam int unsigned PC_W    = 6;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SAT_W   = 3;
    localparam int          MAX_CNT = 65535;
    localparam int          MAX_SAT = 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               halt_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic               instr_done;
    logic [PC_W-1:0]    next_pc;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [PC_W-1:0]    current_pc;
    logic [5:0]         offset;
    logic               running;
    logic [CNT_W-1:0]   retired;

    logic               s_imem_req;
    logic [PC_W-1:0]    s_imem_addr;
    logic [INSTR_W-1:0] s_instr;
    logic               s_instr_valid;
    logic [PC_W-1:0]    s_current_pc;
    logic [5:0]         s_offset;
    logic               s_running;
    logic [SAT_W-1:0]   s_retired;

    pc_fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt_req(halt_req),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
        .i_imem_data(imem_data), .o_instr(instr), .o_instr_valid(instr_valid),
        .i_instr_done(instr_done), .o_current_pc(current_pc), .o_offset(offset),
        .i_next_pc(next_pc), .o_running(running), .o_retired(retired)
    );

    pc_fetch_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt_req(halt_req),
        .o_imem_req(s_imem_req), .o_imem_addr(s_imem_addr), .i_imem_ack(imem_ack),
        .i_imem_data(imem_data), .o_instr(s_instr), .o_instr_valid(s_instr_valid),
        .i_instr_done(instr_done), .o_current_pc(s_current_pc), .o_offset(s_offset),
        .i_next_pc(next_pc), .o_running(s_running), .o_retired(s_retired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model: architectural pc, retire counts, held instruction.
    int m_pc;
    int m_retired;
    int m_sat;
    int m_instr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 0;
        m_retired = 0;
        m_sat     = 0;
        m_instr   = 0;
    endtask

    task automatic model_retire(input int npc);
        m_pc      = npc;
        m_retired = (m_retired < MAX_CNT) ? m_retired + 1 : MAX_CNT;
        m_sat     = (m_sat < MAX_SAT) ? m_sat + 1 : MAX_SAT;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".running"}, 32'(running), 0);
        chk({tag, ".imem_req"}, 32'(imem_req), 0);
        chk({tag, ".instr_valid"}, 32'(instr_valid), 0);
        chk({tag, ".pc"}, 32'(current_pc), m_pc);
        chk({tag, ".instr"}, 32'(instr), m_instr);
        chk({tag, ".retired"}, 32'(retired), m_retired);
        chk({tag, ".sat_retired"}, 32'(s_retired), m_sat);
    endtask

    task automatic do_start(input bit with_halt);
        start    = 1'b1;
        halt_req = with_halt;
        tick();
        start    = 1'b0;
        halt_req = 1'b0;
        chk("start.imem_req", 32'(imem_req), 1);
        chk("start.running", 32'(running), 1);
        chk("start.sat_running", 32'(s_running), 1);
        chk("start.addr", 32'(imem_addr), m_pc);
    endtask

    // One instruction from FETCH through retire. hmode: 0 none, 1 halt in FETCH, 2 halt in EXEC.
    task automatic run_instr(input int waits, input int dly, input logic [15:0] data,
                             input logic [5:0] npc, input int hmode, input bit noise,
                             input bit exp_halt);
        chk("fetch.imem_req", 32'(imem_req), 1);
        chk("fetch.addr", 32'(imem_addr), m_pc);
        chk("fetch.valid", 32'(instr_valid), 0);
        for (int w = 0; w < waits; w++) begin
            if (hmode == 1 && w == 0) halt_req = 1'b1;
            if (noise) begin
                instr_done = 1'b1;
                next_pc    = 6'($urandom);
                start      = 1'b1;
            end
            tick();
            halt_req   = 1'b0;
            instr_done = 1'b0;
            start      = 1'b0;
            chk("wait.imem_req", 32'(imem_req), 1);
            chk("wait.addr", 32'(imem_addr), m_pc);
            chk("wait.retired", 32'(retired), m_retired);
        end
        imem_ack  = 1'b1;
        imem_data = data;
        if (hmode == 1 && waits == 0) halt_req = 1'b1;
        tick();
        imem_ack  = 1'b0;
        halt_req  = 1'b0;
        imem_data = 16'($urandom);
        m_instr   = data;
        chk("exec.valid", 32'(instr_valid), 1);
        chk("exec.instr", 32'(instr), m_instr);
        chk("exec.offset", 32'(offset), 32'(data[5:0]));
        chk("exec.imem_req", 32'(imem_req), 0);
        for (int d = 0; d < dly; d++) begin
            if (hmode == 2 && d == 0) halt_req = 1'b1;
            if (noise) begin
                imem_ack  = 1'b1;
                imem_data = ~data;
                start     = 1'b1;
            end
            tick();
            imem_ack = 1'b0;
            halt_req = 1'b0;
            start    = 1'b0;
            chk("hold.valid", 32'(instr_valid), 1);
            chk("hold.instr", 32'(instr), m_instr);
            chk("hold.offset", 32'(offset), 32'(data[5:0]));
            chk("hold.pc", 32'(current_pc), m_pc);
        end
        instr_done = 1'b1;
        next_pc    = npc;
        if (hmode == 2 && dly == 0) halt_req = 1'b1;
        tick();
        instr_done = 1'b0;
        halt_req   = 1'b0;
        next_pc    = 6'($urandom);
        model_retire(int'(npc));
        chk("retire.pc", 32'(current_pc), m_pc);
        chk("retire.retired", 32'(retired), m_retired);
        chk("retire.sat_retired", 32'(s_retired), m_sat);
        chk("retire.valid", 32'(instr_valid), 0);
        if (exp_halt) begin
            chk("retire.halted_run", 32'(running), 0);
            chk("retire.halted_req", 32'(imem_req), 0);
        end else begin
            chk("retire.next_req", 32'(imem_req), 1);
            chk("retire.next_addr", 32'(imem_addr), m_pc);
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [5:0]  n;
        int          h;

        rst_n      = 1'b0;
        start      = 1'b0;
        halt_req   = 1'b0;
        imem_ack   = 1'b0;
        imem_data  = '0;
        instr_done = 1'b0;
        next_pc    = '0;
        model_reset();
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Zero-wait first fetch of 0x1234 at address 0.
        do_start(1'b0);
        run_instr(0, 0, 16'h1234, 6'd1, 0, 1'b0, 1'b0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        check_idle("reset2");

        // Sequential run with 3 wait cycles and done one cycle after valid.
        do_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            n = 6'(m_pc + 1);
            run_instr(3, 1, d, n, 0, 1'b0, 1'b0);
        end
        chk("seq.retired5", 32'(retired), 5);

        // Branch targets around the top of the 6-bit space.
        run_instr(1, 0, 16'($urandom), 6'd62, 0, 1'b0, 1'b0);
        run_instr(0, 0, 16'($urandom), 6'd3, 0, 1'b0, 1'b0);
        chk("wrap.addr3", 32'(imem_addr), 3);
        run_instr(2, 1, 16'($urandom), 6'd63, 0, 1'b0, 1'b0);
        run_instr(0, 2, 16'($urandom), 6'd0, 0, 1'b0, 1'b0);
        chk("wrap.addr0", 32'(imem_addr), 0);

        // Halt during the fetch wait, then ignored inputs while halted.
        run_instr(2, 1, 16'($urandom), 6'd20, 1, 1'b0, 1'b1);
        instr_done = 1'b1;
        imem_ack   = 1'b1;
        imem_data  = 16'hBEEF;
        halt_req   = 1'b1;
        next_pc    = 6'd45;
        for (int i = 0; i < 3; i++) tick();
        instr_done = 1'b0;
        imem_ack   = 1'b0;
        halt_req   = 1'b0;
        check_idle("halt_idle");

        do_start(1'b0);
        chk("restart.addr20", 32'(imem_addr), 20);
        run_instr(2, 2, 16'($urandom), 6'd21, 0, 1'b1, 1'b0);
        run_instr(0, 2, 16'($urandom), 6'd30, 2, 1'b1, 1'b1);
        check_idle("halt_exec");

        // start together with halt_req: exactly one instruction.
        do_start(1'b1);
        run_instr(1, 0, 16'($urandom), 6'd40, 0, 1'b0, 1'b1);
        check_idle("one_shot");
        do_start(1'b0);

        for (int i = 0; i < 24; i++) begin
            h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      16'($urandom), 6'($urandom), h, 1'($urandom), h != 0);
            if (h != 0) begin
                check_idle("rand_halt");
                do_start(1'b0);
            end
        end

        // Reset in the middle of EXEC at pc 17 with 9 retired.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        check_idle("reset3");
        do_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            run_instr(int'($urandom_range(0, 2)), 0, 16'($urandom), 6'($urandom), 0, 1'b0,
                      1'b0);
        end
        run_instr(1, 0, 16'($urandom), 6'd17, 0, 1'b0, 1'b0);
        imem_ack  = 1'b1;
        imem_data = 16'hA5C3;
        tick();
        imem_ack = 1'b0;
        chk("midexec.valid", 32'(instr_valid), 1);
        chk("midexec.pc", 32'(current_pc), 17);
        chk("midexec.retired", 32'(retired), 9);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_idle("async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("after_async");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
